// File: rtl/period_meter.sv
// period_meter: measures the period and high time of an asynchronous input
// in clk cycles. The result is held in a valid/ack register that reports
// dropped results (overrun) and a saturated period counter (ovf).
module period_meter #(
    parameter int BITS        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            sig_in,
    input  logic            ack,
    output logic            valid,
    output logic [BITS-1:0] period,
    output logic [BITS-1:0] high_time,
    output logic            ovf,
    output logic            overrun,
    output logic            no_signal
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam logic [BITS-1:0] CNT_MAX = {BITS{1'b1}};
    localparam logic [BITS-1:0] CNT_ONE = {{(BITS-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   prev;
    logic                   rise;
    logic                   fall;
    logic [0:0]             state;
    logic [BITS-1:0]        cnt;
    logic [BITS-1:0]        cnt_inc;
    logic [BITS-1:0]        hi_hold;
    logic                   capture;

    assign s       = sync[SYNC_STAGES-1];
    assign rise    = s & ~prev;
    assign fall    = ~s & prev;
    // The counter sticks at its maximum instead of wrapping, so a missing
    // edge reads as "at least this long" rather than a short bogus period.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign capture = (state == ST_MEASURE) && en && rise;

    // Synchronizer chain and edge-detect delay flop for sig_in.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours, exactly like real hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            prev <= s;
        end
    end

    // Measurement FSM: cycle counter, high-time hold and no_signal flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hi_hold   <= '0;
            no_signal <= 1'b0;
        end else if (!en) begin
            // Disabling throws away any partial measurement.
            state     <= ST_IDLE;
            cnt       <= '0;
            no_signal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_MEASURE;
                        cnt   <= CNT_ONE;
                    end
                end
                default: begin
                    if (rise) begin
                        cnt       <= CNT_ONE;
                        no_signal <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            no_signal <= 1'b1;
                        end
                    end
                    // cnt already equals the cycles elapsed since the rise.
                    if (fall) begin
                        hi_hold <= cnt;
                    end
                end
            endcase
        end
    end

    // Result register with valid/ack handshake and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= 1'b0;
            period    <= '0;
            high_time <= '0;
            ovf       <= 1'b0;
            overrun   <= 1'b0;
        end else if (capture) begin
            if (!valid || ack) begin
                valid     <= 1'b1;
                period    <= cnt;
                high_time <= hi_hold;
                ovf       <= (cnt == CNT_MAX);
                if (valid) begin
                    overrun <= 1'b0;
                end
            end else begin
                // Consumer still holds the old result: keep it, flag the loss.
                overrun <= 1'b1;
            end
        end else if (valid && ack) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed checks of period_meter with BITS=16 and BITS=4
// instances driven by the same stimulus.
module tb_period_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        sig_in;
    logic        ack;

    logic        valid, ovf, overrun, no_signal;
    logic [15:0] period, high_time;

    logic        valid4, ovf4, overrun4, no_signal4;
    logic [3:0]  period4, high_time4;

    int n_tests = 0;
    int n_fail  = 0;

    logic ack_level;

    // snapshots taken inside sq()
    logic        s3_v, s3_ovr, s3_ovf, s3_ns, s4_v, sa_v, sa_ovr;
    logic [15:0] s3_per, s3_hi;
    logic        s3_v4, s3_ovf4, s3_ns4, end_ns4;
    logic [3:0]  s3_per4, s3_hi4;

    period_meter #(.BITS(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in), .ack(ack),
        .valid(valid), .period(period), .high_time(high_time),
        .ovf(ovf), .overrun(overrun), .no_signal(no_signal)
    );

    period_meter #(.BITS(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in), .ack(ack),
        .valid(valid4), .period(period4), .high_time(high_time4),
        .ovf(ovf4), .overrun(overrun4), .no_signal(no_signal4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sig_in = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One sig_in period: hi ticks high then lo ticks low. The capture caused
    // by this cycle's rise lands on tick 3; ack is pulsed on tick ack_at.
    task automatic sq(input int hi, input int lo, input int ack_at);
        for (int i = 1; i <= hi + lo; i++) begin
            sig_in = (i <= hi);
            ack    = ack_level | (i == ack_at);
            tick();
            if (i == 3) begin
                s3_v = valid; s3_per = period; s3_hi = high_time;
                s3_ovf = ovf; s3_ovr = overrun; s3_ns = no_signal;
                s3_v4 = valid4; s3_per4 = period4; s3_hi4 = high_time4;
                s3_ovf4 = ovf4; s3_ns4 = no_signal4;
            end
            if (i == 4) s4_v = valid;
            if (i == ack_at) begin
                sa_v = valid; sa_ovr = overrun;
            end
        end
        ack     = ack_level;
        end_ns4 = no_signal4;
    endtask

    initial begin
        int nvalid;
        reset = 1'b1; en = 1'b1; sig_in = 1'b0; ack = 1'b0; ack_level = 1'b0;
        #2;
        check("rst_valid", 32'(valid), 0);
        check("rst_period", 32'(period), 0);
        check("rst_high", 32'(high_time), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_nosig", 32'(no_signal), 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: 10/4 square wave, ack tied high
        ack_level = 1'b1;
        sq(4, 6, 0);
        check("t1_first_rise_no_valid", 32'(s3_v), 0);
        for (int c = 0; c < 3; c++) begin
            sq(4, 6, 0);
            check("t1_valid", 32'(s3_v), 1);
            check("t1_period", 32'(s3_per), 10);
            check("t1_high", 32'(s3_hi), 4);
            check("t1_ovf", 32'(s3_ovf), 0);
            check("t1_overrun", 32'(s3_ovr), 0);
            check("t1_valid_one_cycle", 32'(s4_v), 0);
        end

        // 2: held result, overrun, ack, ack coincident with capture
        ack_level = 1'b0;
        do_reset();
        sq(4, 6, 0);
        check("t2_first_no_valid", 32'(s3_v), 0);
        sq(4, 8, 0);
        check("t2_valid", 32'(s3_v), 1);
        check("t2_period", 32'(s3_per), 10);
        check("t2_overrun0", 32'(s3_ovr), 0);
        sq(4, 7, 6);
        check("t2_ovr_valid", 32'(s3_v), 1);
        check("t2_ovr_set", 32'(s3_ovr), 1);
        check("t2_ovr_period_held", 32'(s3_per), 10);
        check("t2_ack_valid", 32'(sa_v), 0);
        check("t2_ack_overrun", 32'(sa_ovr), 0);
        sq(4, 6, 0);
        check("t2_fresh_valid", 32'(s3_v), 1);
        check("t2_fresh_period", 32'(s3_per), 11);
        check("t2_fresh_overrun", 32'(s3_ovr), 0);
        sq(4, 6, 3);
        check("t2_ackcap_valid", 32'(sa_v), 1);
        check("t2_ackcap_period", 32'(s3_per), 10);
        check("t2_ackcap_overrun", 32'(s3_ovr), 0);

        // 3: BITS=4 saturation
        ack_level = 1'b1;
        do_reset();
        sq(1, 30, 0);
        check("t3_first_no_valid", 32'(s3_v4), 0);
        check("t3_nosig_set", 32'(end_ns4), 1);
        sq(4, 6, 0);
        check("t3_sat_valid", 32'(s3_v4), 1);
        check("t3_sat_period", 32'(s3_per4), 15);
        check("t3_sat_high", 32'(s3_hi4), 1);
        check("t3_sat_ovf", 32'(s3_ovf4), 1);
        check("t3_nosig_clear", 32'(s3_ns4), 0);
        sq(4, 6, 0);
        check("t3_next_period", 32'(s3_per4), 10);
        check("t3_next_ovf", 32'(s3_ovf4), 0);
        check("t3_next_high", 32'(s3_hi4), 4);

        // 4: minimum period 2, high 1
        do_reset();
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            for (int h = 1; h >= 0; h--) begin
                sig_in = h[0];
                tick();
                if (valid) begin
                    nvalid++;
                    check("t4_period", 32'(period), 2);
                    check("t4_high", 32'(high_time), 1);
                end
            end
        end
        check("t4_capture_count", 32'(nvalid), 8);

        // 5: en gap mid-wave with a result held
        ack_level = 1'b0;
        do_reset();
        sq(4, 6, 0);
        sq(4, 6, 0);
        check("t5_held_valid", 32'(s3_v), 1);
        en = 1'b0;
        sig_in = 1'b1;
        repeat (4) tick();
        sig_in = 1'b0;
        tick();
        en = 1'b1;
        repeat (5) tick();
        check("t5_gap_valid", 32'(valid), 1);
        check("t5_gap_period", 32'(period), 10);
        check("t5_gap_overrun", 32'(overrun), 0);
        sq(4, 8, 8);
        check("t5_first_rise_no_cap", 32'(s3_ovr), 0);
        check("t5_first_rise_held", 32'(s3_per), 10);
        check("t5_ack_clears", 32'(sa_v), 0);
        sq(4, 6, 0);
        check("t5_resume_valid", 32'(s3_v), 1);
        check("t5_resume_period", 32'(s3_per), 12);
        check("t5_resume_high", 32'(s3_hi), 4);

        // 6: async reset mid-period with valid and overrun set
        do_reset();
        sq(4, 6, 0);
        sq(4, 6, 0);
        sq(4, 6, 0);
        check("t6_pre_overrun", 32'(s3_ovr), 1);
        check("t6_pre_valid", 32'(s3_v), 1);
        sig_in = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(valid), 0);
        check("t6_rst_overrun", 32'(overrun), 0);
        check("t6_rst_period", 32'(period), 0);
        check("t6_rst_high", 32'(high_time), 0);
        check("t6_rst_ovf", 32'(ovf), 0);
        sig_in = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        sq(4, 6, 0);
        check("t6_first_rise_no_valid", 32'(s3_v), 0);
        sq(4, 6, 0);
        check("t6_second_valid", 32'(s3_v), 1);
        check("t6_second_period", 32'(s3_per), 10);
        check("t6_second_high", 32'(s3_hi), 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
